// File: rtl/map_pkg.sv
// Shared constants, direction codes and FSM state type for the map collision checker.
package map_pkg;

    localparam int MAP_COLS  = 40;
    localparam int MAP_ROWS  = 15;
    localparam int TILE_W    = 20;
    localparam int TILE_H    = 40;
    localparam int SCR_W     = 800;
    localparam int SCR_H     = 600;

    // Reciprocal multipliers: (p * MUL) >> 16 equals p / TILE_{W,H} over the screen range.
    localparam int DIV20_MUL = 3277;
    localparam int DIV40_MUL = 1639;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_TILE,
        ST_C0,
        ST_C1,
        ST_C2,
        ST_C3,
        ST_DONE
    } state_t;

endpackage

// File: rtl/map_tile_index.sv
// Combinational pixel -> tile converter; one instance is time-shared across the four corners.
module map_tile_index
    import map_pkg::*;
(
    input  logic [9:0] px,
    input  logic [9:0] py,
    output logic [3:0] row,
    output logic [5:0] col,
    output logic [9:0] idx
);

    assign col = 6'((22'(px) * 22'(DIV20_MUL)) >> 16);
    assign row = 4'((20'(py) * 20'(DIV40_MUL)) >> 16);
    assign idx = 10'(row) * 10'(MAP_COLS) + 10'(col);

endmodule

// File: rtl/map_collision.sv
// Movement arbiter: checks a sprite's candidate position against screen edges and map walls.
module map_collision
    import map_pkg::*;
#(
    parameter int SPR_W = 16,
    parameter int SPR_H = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [599:0] map,
    input  logic         req,
    input  logic [9:0]   x,
    input  logic [9:0]   y,
    input  logic [1:0]   dir,
    input  logic [3:0]   step,
    output logic         busy,
    output logic         done,
    output logic         blocked,
    output logic [9:0]   new_x,
    output logic [9:0]   new_y,
    output state_t       dbg_state
);

    // Handshake: req is taken only in IDLE; busy is high from the accepting edge through
    // the done cycle, and any req seen while busy is dropped rather than queued.

    localparam logic signed [10:0] XMAX = 11'(SCR_W - SPR_W);
    localparam logic signed [10:0] YMAX = 11'(SCR_H - SPR_H);
    localparam logic signed [10:0] CW   = 11'(SPR_W - 1);
    localparam logic signed [10:0] CH   = 11'(SPR_H - 1);

    state_t state, state_n;

    logic [9:0]         x_q, y_q;
    logic [1:0]         dir_q;
    logic [3:0]         step_q;
    logic signed [10:0] cx, cy;
    logic               oob, hit;
    logic [9:0]         px0, px1, py0, py1;
    logic               blocked_q;
    logic [9:0]         new_x_q, new_y_q;

    logic signed [10:0] xs, ys, st, cand_x, cand_y;
    logic               oob_c;
    logic [9:0]         sel_px, sel_py;
    logic [3:0]         t_row;
    logic [5:0]         t_col;
    logic [9:0]         t_idx;
    logic               corner_hit, blk;

    always_comb begin
        xs     = $signed({1'b0, x_q});
        ys     = $signed({1'b0, y_q});
        st     = $signed({7'd0, step_q});
        cand_x = xs;
        cand_y = ys;
        case (dir_q)
            DIR_UP:    cand_y = ys - st;
            DIR_DOWN:  cand_y = ys + st;
            DIR_LEFT:  cand_x = xs - st;
            DIR_RIGHT: cand_x = xs + st;
            default:   cand_x = xs;
        endcase
        oob_c = (cand_x < 11'sd0) || (cand_y < 11'sd0) || (cand_x > XMAX) || (cand_y > YMAX);
    end

    // Corner order: top-left, top-right, bottom-left, bottom-right.
    always_comb begin
        sel_px = px0;
        sel_py = py0;
        case (state)
            ST_C1:   begin sel_px = px1; sel_py = py0; end
            ST_C2:   begin sel_px = px0; sel_py = py1; end
            ST_C3:   begin sel_px = px1; sel_py = py1; end
            default: begin sel_px = px0; sel_py = py0; end
        endcase
    end

    map_tile_index u_tile (
        .px  (sel_px),
        .py  (sel_py),
        .row (t_row),
        .col (t_col),
        .idx (t_idx)
    );

    // Out-of-bounds moves skip the lookup but still walk C0..C3 to keep latency fixed.
    assign corner_hit = !oob && (t_row < 4'(MAP_ROWS)) && (t_col < 6'(MAP_COLS)) && map[t_idx];
    assign blk        = oob | hit | corner_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        busy    = 1'b1;
        done    = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (req) state_n = ST_CALC;
            end
            ST_CALC: state_n = ST_TILE;
            ST_TILE: state_n = ST_C0;
            ST_C0:   state_n = ST_C1;
            ST_C1:   state_n = ST_C2;
            ST_C2:   state_n = ST_C3;
            ST_C3:   state_n = ST_DONE;
            ST_DONE: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q       <= '0;
            y_q       <= '0;
            dir_q     <= '0;
            step_q    <= '0;
            cx        <= '0;
            cy        <= '0;
            oob       <= 1'b0;
            hit       <= 1'b0;
            px0       <= '0;
            px1       <= '0;
            py0       <= '0;
            py1       <= '0;
            blocked_q <= 1'b0;
            new_x_q   <= '0;
            new_y_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (req) begin
                    x_q    <= x;
                    y_q    <= y;
                    dir_q  <= dir;
                    step_q <= step;
                end
                ST_CALC: begin
                    cx  <= cand_x;
                    cy  <= cand_y;
                    oob <= oob_c;
                    hit <= 1'b0;
                end
                ST_TILE: begin
                    px0 <= cx[9:0];
                    px1 <= 10'(cx + CW);
                    py0 <= cy[9:0];
                    py1 <= 10'(cy + CH);
                end
                ST_C0, ST_C1, ST_C2: hit <= hit | corner_hit;
                ST_C3: begin
                    hit       <= hit | corner_hit;
                    blocked_q <= blk;
                    new_x_q   <= blk ? x_q : cx[9:0];
                    new_y_q   <= blk ? y_q : cy[9:0];
                end
                default: ;
            endcase
        end
    end

    assign blocked   = blocked_q;
    assign new_x     = new_x_q;
    assign new_y     = new_y_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_map_collision.sv
// Directed and swept bench for map_collision; a negedge monitor scores every done against a queue.
`timescale 1ns/1ps
module tb_map_collision;
    import map_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [599:0] map_r;
    logic         req;
    logic [9:0]   x, y;
    logic [1:0]   dir;
    logic [3:0]   step;
    logic         busy, done, blocked;
    logic [9:0]   new_x, new_y;
    state_t       dbg_state;

    logic [20:0]  exp_q[$];
    logic [20:0]  mon_exp;
    int           checks = 0;
    int           errors = 0;

    map_collision dut (
        .clk       (clk),
        .rst       (rst),
        .map       (map_r),
        .req       (req),
        .x         (x),
        .y         (y),
        .dir       (dir),
        .step      (step),
        .busy      (busy),
        .done      (done),
        .blocked   (blocked),
        .new_x     (new_x),
        .new_y     (new_y),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got blocked=%0d new_x=%0d new_y=%0d expected no done",
                         blocked, new_x, new_y);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({blocked, new_x, new_y} !== mon_exp) begin
                    errors++;
                    $display("FAIL result: got blocked=%0d new_x=%0d new_y=%0d expected blocked=%0d new_x=%0d new_y=%0d",
                             blocked, new_x, new_y, mon_exp[20], mon_exp[19:10], mon_exp[9:0]);
                end
            end
        end
    end

    // Reference: sprite is smaller than a tile, so the covered row/col ranges fully describe overlap.
    function automatic logic [20:0] ref_move(input int xi, input int yi, input int d, input int s,
                                             input logic [599:0] m);
        int   cx, cy;
        logic hit;
        cx  = xi;
        cy  = yi;
        hit = 1'b0;
        case (d)
            0: cy = cy - s;
            1: cy = cy + s;
            2: cx = cx - s;
            default: cx = cx + s;
        endcase
        if (cx < 0 || cy < 0 || cx + 15 > 799 || cy + 31 > 599)
            return {1'b1, 10'(xi), 10'(yi)};
        for (int r = cy / 40; r <= (cy + 31) / 40; r++)
            for (int c = cx / 20; c <= (cx + 15) / 20; c++)
                hit |= m[r * 40 + c];
        if (hit) return {1'b1, 10'(xi), 10'(yi)};
        return {1'b0, 10'(cx), 10'(cy)};
    endfunction

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic start(input int xi, input int yi, input int d, input int s, input logic [20:0] e);
        x    = 10'(xi);
        y    = 10'(yi);
        dir  = 2'(d);
        step = 4'(s);
        req  = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    // done occupies the cycle after edge k+6; returns in the cycle after done so the next req is accepted.
    task automatic finish_req();
        int n;
        check("busy_rise", int'(busy), 1);
        wait_done(n);
        check("latency", n, 6);
        @(negedge clk);
        check("busy_fall", int'(busy), 0);
    endtask

    task automatic run(input int xi, input int yi, input int d, input int s,
                       input int eb, input int ex, input int ey);
        start(xi, yi, d, s, {1'(eb), 10'(ex), 10'(ey)});
        finish_req();
    endtask

    initial begin
        int n;
        int tiles[5];
        logic [20:0] e;
        tiles = '{0, 39, 86, 321, 599};

        rst = 1'b1; req = 1'b0; map_r = '0;
        x = '0; y = '0; dir = '0; step = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_blocked", int'(blocked), 0);
        check("rst_new_x", int'(new_x), 0);
        check("rst_new_y", int'(new_y), 0);
        check("rst_state", int'(dbg_state), int'(ST_IDLE));
        rst = 1'b0;
        @(negedge clk);

        // Directed moves
        run(100, 80, DIR_RIGHT, 4, 0, 104, 80);
        map_r[86] = 1'b1;
        run(100, 80, DIR_RIGHT, 8, 1, 100, 80);
        run(120, 80, DIR_LEFT, 0, 1, 120, 80);
        run(100, 80, DIR_UP, 5, 0, 100, 75);
        run(120, 30, DIR_DOWN, 15, 0, 120, 45);
        run(120, 50, DIR_DOWN, 15, 1, 120, 50);
        map_r = '0;
        run(0, 80, DIR_LEFT, 1, 1, 0, 80);
        run(784, 80, DIR_RIGHT, 1, 1, 784, 80);
        run(784, 80, DIR_RIGHT, 0, 0, 784, 80);
        run(100, 568, DIR_DOWN, 0, 0, 100, 568);
        run(100, 568, DIR_DOWN, 1, 1, 100, 568);
        run(100, 0, DIR_UP, 1, 1, 100, 0);

        // Second req at edge k+3 must be dropped
        start(100, 80, DIR_RIGHT, 4, {1'b0, 10'd104, 10'd80});
        repeat (2) @(negedge clk);
        x = 10'd200; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_done(n);
        check("busy_ignore_latency", n, 3);
        repeat (12) @(negedge clk);
        check("busy_ignore_queue", exp_q.size(), 0);

        // Reset at edge k+4 aborts the request
        run(100, 0, DIR_UP, 1, 1, 100, 0);
        x = 10'd300; y = 10'd200; dir = DIR_RIGHT; step = 4'd2; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_blocked", int'(blocked), 0);
        check("midrst_new_x", int'(new_x), 0);
        check("midrst_new_y", int'(new_y), 0);
        check("midrst_state", int'(dbg_state), int'(ST_IDLE));
        repeat (12) @(negedge clk);
        run(300, 200, DIR_RIGHT, 2, 0, 302, 200);

        // Single-tile sweep over every grid position
        foreach (tiles[t]) begin
            map_r = '0;
            map_r[tiles[t]] = 1'b1;
            for (int r = 0; r < 15; r++) begin
                for (int c = 0; c < 40; c++) begin
                    e = ref_move(c * 20, r * 40, (r + c) % 4, (r * 7 + c * 3) % 16, map_r);
                    start(c * 20, r * 40, (r + c) % 4, (r * 7 + c * 3) % 16, e);
                    finish_req();
                end
            end
        end

        repeat (4) @(negedge clk);
        check("final_queue", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
